// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one Booth multiplier between two requesters.
// Latches the winner's operands, runs the start/ready handshake with a watchdog,
// and returns the product (or a timeout error) to the owner as a one-cycle pulse.
module booth_mult_arbiter #(
    parameter int unsigned XW      = 6,
    parameter int unsigned YW      = 7,
    parameter int unsigned PW      = 13,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [XW-1:0] i_req0_x,
    input  logic [YW-1:0] i_req0_y,
    output logic          o_req0_ack,
    output logic          o_rsp0_valid,
    output logic [PW-1:0] o_rsp0_p,
    output logic          o_rsp0_err,
    input  logic          i_req1_valid,
    input  logic [XW-1:0] i_req1_x,
    input  logic [YW-1:0] i_req1_y,
    output logic          o_req1_ack,
    output logic          o_rsp1_valid,
    output logic [PW-1:0] o_rsp1_p,
    output logic          o_rsp1_err,
    output logic          o_mul_start,
    output logic [XW-1:0] o_mul_x,
    output logic [YW-1:0] o_mul_y,
    input  logic          i_mul_ready,
    input  logic [PW-1:0] i_mul_p
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_t;

    state_t        r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [XW-1:0] r_mul_x;
    logic [YW-1:0] r_mul_y;
    logic          r_mul_start;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [PW-1:0] r_rsp0_p;
    logic [PW-1:0] r_rsp1_p;
    logic          r_rsp0_err;
    logic          r_rsp1_err;

    logic w_grant;
    logic w_accept;
    logic w_wait;
    logic w_exit;
    logic w_timeout;
    logic w_done;
    logic w_abort;
    logic w_finish;

    // Arbitration, handshake exit and watchdog decode
    always_comb begin
        // On a tie the requester that did not win last time gets the unit
        w_grant   = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
        w_accept  = (r_state == StIdle) & (i_req0_valid | i_req1_valid) & i_mul_ready;
        w_wait    = (r_state == StWaitBusy) | (r_state == StWaitDone);
        // WAIT_BUSY leaves when the multiplier drops ready, WAIT_DONE when it raises it
        w_exit    = (r_state == StWaitBusy) ? ~i_mul_ready : i_mul_ready;
        w_timeout = (r_cnt == CW'(TIMEOUT));
        w_done    = (r_state == StWaitDone) & i_mul_ready;
        w_abort   = w_wait & ~w_exit & w_timeout;
        w_finish  = w_done | w_abort;
    end

    // Control FSM with registered start and response pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_mul_x      <= '0;
            r_mul_y      <= '0;
            r_mul_start  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_mul_start  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_mul_x      <= w_grant ? i_req1_x : i_req0_x;
                        r_mul_y      <= w_grant ? i_req1_y : i_req0_y;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_mul_start  <= 1'b1;
                        r_state      <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_cnt   <= '0;
                    r_state <= StWaitBusy;
                end
                StWaitBusy: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_abort) begin
                        r_state <= StResp;
                    end else if (!i_mul_ready) begin
                        r_state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_finish) begin
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
            if (w_finish) begin
                r_rsp0_valid <= ~r_owner;
                r_rsp1_valid <= r_owner;
            end
        end
    end

    // Per-requester result registers; only the owner's copy is updated
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp0_p   <= '0;
            r_rsp1_p   <= '0;
            r_rsp0_err <= 1'b0;
            r_rsp1_err <= 1'b0;
        end else if (w_finish) begin
            if (r_owner) begin
                r_rsp1_p   <= w_abort ? '0 : i_mul_p;
                r_rsp1_err <= w_abort;
            end else begin
                r_rsp0_p   <= w_abort ? '0 : i_mul_p;
                r_rsp0_err <= w_abort;
            end
        end
    end

    assign o_req0_ack   = w_accept & ~w_grant;
    assign o_req1_ack   = w_accept & w_grant;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp0_p     = r_rsp0_p;
    assign o_rsp1_p     = r_rsp1_p;
    assign o_rsp0_err   = r_rsp0_err;
    assign o_rsp1_err   = r_rsp1_err;
    assign o_mul_start  = r_mul_start;
    assign o_mul_x      = r_mul_x;
    assign o_mul_y      = r_mul_y;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural multiplier stub, random/directed
// requesters, and a transaction-level reference model checked every cycle.
module tb_booth_mult_arbiter;

    localparam int unsigned XW      = 6;
    localparam int unsigned YW      = 7;
    localparam int unsigned PW      = 13;
    localparam int unsigned TIMEOUT = 63;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [XW-1:0] x0 = '0, x1 = '0;
    logic [YW-1:0] y0 = '0, y1 = '0;
    logic          ack0, ack1, rv0, rv1, re0, re1, start, mul_ready;
    logic [PW-1:0] rp0, rp1, mul_p;
    logic [XW-1:0] mx;
    logic [YW-1:0] my;

    logic          force_busy = 1'b0;
    logic          stub_hang  = 1'b0;
    logic          stub_long  = 1'b0;
    logic          st_ready   = 1'b1;
    logic [PW-1:0] st_p       = '0;
    int            st_phase   = 0;
    int            st_cnt     = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mul_ready = force_busy ? 1'b0 : st_ready;
    assign mul_p     = st_p;

    booth_mult_arbiter #(
        .XW      (XW),
        .YW      (YW),
        .PW      (PW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .i_req0_x     (x0),
        .i_req0_y     (y0),
        .o_req0_ack   (ack0),
        .o_rsp0_valid (rv0),
        .o_rsp0_p     (rp0),
        .o_rsp0_err   (re0),
        .i_req1_valid (v1),
        .i_req1_x     (x1),
        .i_req1_y     (y1),
        .o_req1_ack   (ack1),
        .o_rsp1_valid (rv1),
        .o_rsp1_p     (rp1),
        .o_rsp1_err   (re1),
        .o_mul_start  (start),
        .o_mul_x      (mx),
        .o_mul_y      (my),
        .i_mul_ready  (mul_ready),
        .i_mul_p      (mul_p)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Two's-complement product truncated to PW bits
    function automatic logic [PW-1:0] ref_prod(input logic [XW-1:0] x, input logic [YW-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[PW-1:0];
    endfunction

    // Multiplier stub: drops ready 0/1 cycles after start, busy 1..6 cycles
    // (or 100 when stub_long), then presents the product; stub_hang ignores start.
    always @(posedge clk) begin
        if (rst) begin
            st_ready <= 1'b1;
            st_phase <= 0;
            st_cnt   <= 0;
            st_p     <= '0;
        end else begin
            case (st_phase)
                0: begin
                    if (start && !stub_hang) begin
                        st_p   <= PW'($urandom);
                        st_cnt <= stub_long ? 100 : int'($urandom_range(6, 1));
                        if ($urandom_range(1, 0) == 1) begin
                            st_ready <= 1'b0;
                            st_phase <= 2;
                        end else begin
                            st_phase <= 1;
                        end
                    end
                end
                1: begin
                    st_ready <= 1'b0;
                    st_phase <= 2;
                end
                default: begin
                    if (st_cnt <= 1) begin
                        st_ready <= 1'b1;
                        st_p     <= ref_prod(mx, my);
                        st_phase <= 0;
                    end else begin
                        st_cnt <= st_cnt - 1;
                    end
                end
            endcase
        end
    end

    // Reference model: one transaction in flight, round-robin on ties
    logic          pending = 1'b0;
    int            owner   = 0;
    int            last    = 1;
    int            ack_cyc = 0;
    int            cyc     = 0;
    logic [XW-1:0] ex      = '0;
    logic [YW-1:0] ey      = '0;
    logic [PW-1:0] ep      = '0;
    logic          eerr    = 1'b0;
    logic [PW-1:0] held0   = '0, held1 = '0;
    logic          held_e0 = 1'b0, held_e1 = 1'b0;
    logic          start_due = 1'b0;
    int            grant_log[$];

    always @(negedge clk) begin
        logic [1:0] eack;
        int         win;
        cyc++;
        if (rst) begin
            pending   = 1'b0;
            last      = 1;
            held0     = '0;
            held1     = '0;
            held_e0   = 1'b0;
            held_e1   = 1'b0;
            start_due = 1'b0;
        end else begin
            eack = 2'b00;
            win  = 0;
            if (!pending && mul_ready && (v0 || v1)) begin
                win = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
                eack[win] = 1'b1;
            end
            check_val("ack", {ack1, ack0}, eack);
            check_val("mul_start", start, start_due);
            start_due = (eack != 2'b00);
            if (pending) begin
                check_val("mul_x", mx, ex);
                check_val("mul_y", my, ey);
            end
            if (rv0 || rv1) begin
                if (!pending) begin
                    check_val("rsp_unexpected", {rv1, rv0}, 2'b00);
                end else begin
                    check_val("rsp_owner", {rv1, rv0}, (owner == 1) ? 2'b10 : 2'b01);
                    if (owner == 1) begin
                        held1   = ep;
                        held_e1 = eerr;
                    end else begin
                        held0   = ep;
                        held_e0 = eerr;
                    end
                    if (eerr) check_val("timeout_latency", cyc - ack_cyc, TIMEOUT + 3);
                    pending = 1'b0;
                end
            end
            check_val("rsp0_p", rp0, held0);
            check_val("rsp0_err", re0, held_e0);
            check_val("rsp1_p", rp1, held1);
            check_val("rsp1_err", re1, held_e1);
            if (eack != 2'b00) begin
                pending = 1'b1;
                owner   = win;
                last    = win;
                ex      = (win == 1) ? x1 : x0;
                ey      = (win == 1) ? y1 : y0;
                eerr    = stub_hang || stub_long;
                ep      = eerr ? '0 : ref_prod(ex, ey);
                ack_cyc = cyc;
                grant_log.push_back(win);
            end
        end
    end

    // One cycle of requester behaviour: drop valid after ack, re-raise with pct chance
    task automatic step(input int p0, input int p1);
        logic a0, a1;
        @(negedge clk);
        a0 = ack0;
        a1 = ack1;
        @(posedge clk);
        #1;
        if (a0) v0 = 1'b0;
        if (a1) v1 = 1'b0;
        if (!v0 && int'($urandom_range(99, 0)) < p0) begin
            v0 = 1'b1;
            x0 = XW'($urandom);
            y0 = YW'($urandom);
        end
        if (!v1 && int'($urandom_range(99, 0)) < p1) begin
            v1 = 1'b1;
            x1 = XW'($urandom);
            y1 = YW'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((pending || v0 || v1) && n < 400) begin
            step(0, 0);
            n++;
        end
        check_val("drain_bound", (n < 400), 1);
        repeat (2) step(0, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctrl"}, {ack0, ack1, rv0, rv1, re0, re1, start}, 0);
        check_val({tag, "_rsp0_p"}, rp0, 0);
        check_val({tag, "_rsp1_p"}, rp1, 0);
        check_val({tag, "_mul_xy"}, {mx, my}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request from requester 0
        x0 = 6'd5;
        y0 = 7'd3;
        v0 = 1'b1;
        drain();
        check_val("single_p", rp0, 13'd15);
        check_val("single_err", re0, 0);
        check_val("single_rsp1_p", rp1, 0);

        // Simultaneous requests right after reset: requester 0 first
        pulse_reset();
        base = grant_log.size();
        x0 = 6'd5;
        y0 = 7'd3;
        v0 = 1'b1;
        x1 = 6'h3E;
        y1 = 7'd4;
        v1 = 1'b1;
        drain();
        check_val("simul_count", grant_log.size() - base, 2);
        if (grant_log.size() >= base + 2) begin
            check_val("simul_first", grant_log[base], 0);
            check_val("simul_second", grant_log[base+1], 1);
        end
        check_val("simul_p0", rp0, 13'd15);
        check_val("simul_p1", rp1, 13'h1FF8);

        // Fairness with both requesters continuously valid
        base = grant_log.size();
        n = 0;
        while (grant_log.size() < base + 6 && n < 300) begin
            step(100, 100);
            n++;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        drain();
        check_val("fair_count", grant_log.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (grant_log.size() > base + i) check_val("fair_order", grant_log[base+i], i % 2);
        end

        // Multiplier busy in IDLE: no ack until ready returns
        force_busy = 1'b1;
        base = grant_log.size();
        x1 = XW'($urandom);
        y1 = YW'($urandom);
        v1 = 1'b1;
        repeat (6) step(0, 0);
        check_val("busy_noack", grant_log.size() - base, 0);
        force_busy = 1'b0;
        drain();
        check_val("busy_then_ack", grant_log.size() - base, 1);

        // Watchdog: multiplier never leaves ready, then never finishes
        stub_hang = 1'b1;
        x0 = 6'd7;
        y0 = 7'd9;
        v0 = 1'b1;
        drain();
        stub_hang = 1'b0;
        check_val("hang_err", re0, 1);
        check_val("hang_p", rp0, 0);
        stub_long = 1'b1;
        x1 = 6'd11;
        y1 = 7'd2;
        v1 = 1'b1;
        drain();
        stub_long = 1'b0;
        check_val("long_err", re1, 1);
        check_val("long_p", rp1, 0);
        x0 = 6'h21;
        y0 = 7'h55;
        v0 = 1'b1;
        drain();
        check_val("after_to_err", re0, 0);
        check_val("after_to_p", rp0, ref_prod(6'h21, 7'h55));

        // Reset while the multiplier is busy (WAIT_DONE)
        stub_long = 1'b1;
        x0 = 6'd3;
        y0 = 7'd3;
        v0 = 1'b1;
        n = 0;
        while (!(pending && !mul_ready) && n < 50) begin
            step(0, 0);
            n++;
        end
        repeat (2) step(0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        stub_long = 1'b0;
        @(negedge clk);
        check_all_zero("midop_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) step(0, 0);
        base = grant_log.size();
        x1 = 6'h15;
        y1 = 7'h7F;
        v1 = 1'b1;
        drain();
        check_val("post_reset_count", grant_log.size() - base, 1);
        if (grant_log.size() > base) check_val("post_reset_req1", grant_log[base], 1);

        // Random traffic with occasional hung operations
        begin
            int p0 = 50;
            int p1 = 50;
            for (int c = 0; c < 1500; c++) begin
                if (c % 100 == 0) begin
                    p0 = int'($urandom_range(90, 10));
                    p1 = int'($urandom_range(90, 10));
                end
                if (!pending) stub_hang = ($urandom_range(39, 0) == 0);
                step(p0, p1);
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        n = 0;
        while (pending && n < 200) begin
            step(0, 0);
            n++;
        end
        stub_hang = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one Booth multiplier unit between two independent requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier's start/ready handshake, captures the product and returns it to the owning requester with a one-cycle response pulse.
- Includes a watchdog that aborts and flags an error if the multiplier never completes. Sits between the multiplier datapath/controller pair and its client blocks.

Parameters:
- XW, 6, multiplicand width (mul_x, reqN_x).
- YW, 7, multiplier width (mul_y, reqN_y).
- PW, 13, product width (XW+YW).
- TIMEOUT, 63, maximum cycles spent in WAIT_BUSY+WAIT_DONE before abort (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending; held until req0_ack.
- req0_x  in  XW  requester 0 multiplicand.
- req0_y  in  YW  requester 0 multiplier.
- req0_ack  out  1  one-cycle pulse: request 0 accepted, operands captured this edge.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0 available.
- rsp0_p  out  PW  product for requester 0; holds until its next response.
- rsp0_err  out  1  qualifies rsp0_valid: 1 = timeout abort, rsp0_p = 0.
- req1_valid, req1_x, req1_y, req1_ack, rsp1_valid, rsp1_p, rsp1_err: same as requester 0, for requester 1.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  XW  latched operand, stable from LAUNCH until return to IDLE.
- mul_y  out  YW  latched operand, stable from LAUNCH until return to IDLE.
- mul_ready  in  1  multiplier idle/done level.
- mul_p  in  PW  multiplier product, valid when mul_ready=1 after an operation.

Behaviour:
- Reset: all outputs 0, state IDLE, operand/owner/timeout registers 0, last_grant=1 (so requester 0 wins the first tie). Reset mid-operation abandons the operation silently: no rsp pulse, no ack.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: grant = requester with valid. If both are valid, grant goes to the one not equal to last_grant. Accept only when mul_ready=1.
  - On accept, reqN_ack=1 combinationally in that cycle.
  - At the clock edge: latch x/y into the mul_x/mul_y registers, owner=N, last_grant=N, go to LAUNCH.
  - If mul_ready=0: no ack, stay in IDLE.
- LAUNCH: mul_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for mul_ready=0 (multiplier acknowledged start), then go to WAIT_DONE. The counter increments each cycle.
- WAIT_DONE: wait for mul_ready=1. At that edge latch mul_p into rsp<owner>_p, clear rsp<owner>_err, go to RESP. The counter increments.
- Timeout: if the counter equals TIMEOUT in WAIT_BUSY or WAIT_DONE and the exit condition is false, go to RESP with rsp<owner>_p=0 and rsp<owner>_err=1.
- RESP: rsp<owner>_valid=1 for one cycle; the other requester's rsp outputs are untouched; go to IDLE.
- Latency:
  - ack cycle T, mul_start at T+1.
  - Response pulse is 2 cycles after mul_ready returns high (edge into RESP, then RESP cycle).
  - Minimum IDLE spacing between consecutive grants: 1 cycle.
- One operation in flight at a time. A requester may reassert valid while its previous operation is outstanding; it is not acked until IDLE.
- No response backpressure: the client must consume the rsp pulse.
- A deasserted valid in the same cycle as the grant decision is not acked. Valid is sampled only in IDLE.
- mul_x/mul_y are held constant through the whole operation; the multiplier's controller samples them during its load and add states.
- Products are passed through unmodified; signedness is defined by the multiplier.

Test Plan:
- Single request: req0 x=6'd5, y=7'd3 → req0_ack one cycle, mul_start next cycle, later rsp0_valid pulse with rsp0_p=13'd15, rsp0_err=0; rsp1_valid never asserted.
- Simultaneous requests after reset: req0 (5,3) and req1 (x=6'h3E, y=7'd4) held → requester 0 served first (15), then requester 1 (-8 = 13'h1FF8); ack order 0,1.
- Fairness: both valid continuously for 6 operations → grants strictly alternate 0,1,0,1,0,1; no requester starved.
- Busy multiplier: mul_ready forced 0 while req1 valid in IDLE → no ack and no mul_start until mul_ready=1, then normal flow.
- Timeout: multiplier model never drops mul_ready after start → after TIMEOUT cycles, rsp0_valid=1, rsp0_err=1, rsp0_p=0; next request is then accepted normally.
- Reset mid-operation: rst asserted during WAIT_DONE → next cycle all outputs 0, state IDLE, no rsp pulse; a subsequent req1 is granted first (last_grant=1 reset value means req0 wins ties, but req1 alone wins).
